// File: rtl/arm_mem_pkg.sv
// Shared types and default constants for the wait-state MEM stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arm_mem_pkg;

    // Access controller states: IDLE accepts a new op, WAIT counts down wait states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_DEPTH       = 64;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

    // Wait-state counter width; covers WAIT_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

    // Counter preload for a fresh access. The arrival cycle is itself the first
    // frozen cycle, so the counter starts one below the wait-state count.
    function automatic logic [CNT_W-1:0] wait_preload(input int unsigned wait_cycles);
        logic [CNT_W-1:0] v;
        v = '0;
        if (wait_cycles != 0) begin
            v = CNT_W'(wait_cycles - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/mem_ws_sram.sv
// Data array: DEPTH x DATA_W words, synchronous write, combinational read, no reset.
// Latency: write lands at the clock edge, read data is valid in the same cycle.
// Backpressure: none; the caller decides when to write.
//
// Ports:
//   clk    - write clock
//   we     - write enable, one word per asserted edge
//   addr   - word index shared by the read and write ports
//   wdata  - write data
//   rdata  - combinational read data at addr
module mem_ws_sram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule

// File: rtl/mem_stage_ws.sv
// MEM stage with data memory, per-access wait states and the MEM/WB register.
// Latency: 1 cycle for non-memory ops and bad addresses, WAIT_CYCLES+1 for valid loads/stores.
// Backpressure: freeze (combinational) stalls upstream while wait states count down.
//
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   mem_w_en_in/_r_en_in - store / load request from EXE (store wins if both)
//   wb_en_in            - writeback enable from EXE
//   alu_result_in       - byte address for memory ops, otherwise ALU result
//   val_rm              - store data
//   pc_in, dest_in      - instruction PC and destination register
//   flush               - squash the current stage contents
//   freeze              - stall request to IF/ID/EXE
//   wb_en .. addr_err   - registered MEM/WB outputs
module mem_stage_ws
    import arm_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_w_en_in,
    input  logic              mem_r_en_in,
    input  logic              wb_en_in,
    input  logic [31:0]       alu_result_in,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [31:0]       pc_in,
    input  logic [3:0]        dest_in,
    input  logic              flush,
    output logic              freeze,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [31:0]       alu_result,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] mem_read_value,
    output logic [3:0]        dest,
    output logic              addr_err
);

    localparam int unsigned      AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = wait_preload(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               HAS_WAIT = (WAIT_CYCLES != 0);

    // ---------------------------------------------------------------- decode
    logic [31:0]       w_off;
    logic [31:0]       w_idx;
    logic              w_aligned;
    logic              w_in_range;
    logic              w_valid;
    logic              w_is_store;
    logic              w_is_load;
    logic              w_mem_op;
    logic              w_good_op;
    logic              w_bad_op;
    logic              w_load_hit;
    logic              w_done;
    logic              w_we;
    logic              w_freeze;
    logic [DATA_W-1:0] w_rd_data;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;

    // Unsigned wrap below BASE_ADDR is harmless: the >= test rejects it.
    assign w_off      = alu_result_in - BASE_ADDR;
    assign w_idx      = w_off >> 2;
    assign w_aligned  = (alu_result_in[1:0] == 2'b00);
    assign w_in_range = (alu_result_in >= BASE_ADDR) && (w_idx < 32'(DEPTH));
    assign w_valid    = w_aligned && w_in_range;

    // A simultaneous load+store request is treated as a store only.
    assign w_is_store = mem_w_en_in;
    assign w_is_load  = mem_r_en_in && !mem_w_en_in;
    assign w_mem_op   = mem_r_en_in || mem_w_en_in;
    assign w_good_op  = w_mem_op && w_valid;
    assign w_bad_op   = w_mem_op && !w_valid;
    assign w_load_hit = w_is_load && w_valid;

    // --------------------------------------------------------------- freeze
    // Depends only on state, counter, flush and the request inputs.
    always_comb begin
        w_freeze = 1'b0;
        if (!flush) begin
            if (r_state == WAIT) begin
                w_freeze = (r_cnt != '0);
            end else begin
                w_freeze = HAS_WAIT && w_good_op;
            end
        end
    end

    assign freeze = w_freeze;

    // A valid access finishes either in its arrival cycle (no wait states)
    // or in the last WAIT cycle. Flush cancels it, so a store is never half-done.
    assign w_done = !flush && w_good_op &&
                    (((r_state == IDLE) && !HAS_WAIT) ||
                     ((r_state == WAIT) && (r_cnt == '0)));
    assign w_we   = w_done && w_is_store;

    // ------------------------------------------------------------ FSM/count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (HAS_WAIT && w_good_op) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- memory
    mem_ws_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_sram (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_idx[AW-1:0]),
        .wdata (val_rm),
        .rdata (w_rd_data)
    );

    // -------------------------------------------------------- MEM/WB register
    logic              r_wb_en;
    logic              r_mem_r_en;
    logic              r_addr_err;
    logic [31:0]       r_alu_result;
    logic [31:0]       r_pc;
    logic [DATA_W-1:0] r_mem_read_value;
    logic [3:0]        r_dest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_en          <= 1'b0;
            r_mem_r_en       <= 1'b0;
            r_addr_err       <= 1'b0;
            r_alu_result     <= '0;
            r_pc             <= '0;
            r_mem_read_value <= '0;
            r_dest           <= '0;
        end else if (flush || w_freeze) begin
            // Bubble: nothing reaches WB while stalled or squashed.
            r_wb_en          <= 1'b0;
            r_mem_r_en       <= 1'b0;
            r_addr_err       <= 1'b0;
            r_alu_result     <= '0;
            r_pc             <= '0;
            r_mem_read_value <= '0;
            r_dest           <= '0;
        end else begin
            // A squashed load must not write back garbage; a squashed store
            // keeps its writeback enable so any side-effect register update survives.
            r_wb_en          <= (w_bad_op && w_is_load) ? 1'b0 : wb_en_in;
            r_mem_r_en       <= w_load_hit;
            r_addr_err       <= w_bad_op;
            r_alu_result     <= alu_result_in;
            r_pc             <= pc_in;
            r_mem_read_value <= w_load_hit ? w_rd_data : '0;
            r_dest           <= dest_in;
        end
    end

    assign wb_en          = r_wb_en;
    assign mem_r_en       = r_mem_r_en;
    assign addr_err       = r_addr_err;
    assign alu_result     = r_alu_result;
    assign pc             = r_pc;
    assign mem_read_value = r_mem_read_value;
    assign dest           = r_dest;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: one instance with two wait states, one with none.
// Latency: expectations are queued at issue and retired when a PC appears on the outputs.
// Backpressure: the driver holds inputs while freeze is high, as upstream would.
module tb_mem_stage_ws;

    typedef struct packed {
        logic        mw;
        logic        mr;
        logic        wb;
        logic [31:0] alu;
        logic [31:0] val;
        logic [31:0] pc;
        logic [3:0]  dest;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        addr_err;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rd;
        logic [3:0]  dest;
    } out_t;

    logic clk;
    logic rst_n;
    in_t  i2, i0;
    out_t o2, o0;

    logic        frz2, wb2, mr2, ae2;
    logic [31:0] alu2, pc2, rd2;
    logic [3:0]  dst2;
    logic        frz0, wb0, mr0, ae0;
    logic [31:0] alu0, pc0, rd0;
    logic [3:0]  dst0;

    out_t q2[$];
    out_t q0[$];
    logic [31:0] mdl2 [64];
    logic [31:0] mdl0 [64];

    int n_checks = 0;
    int n_errors = 0;
    logic frz0_seen = 1'b0;

    mem_stage_ws #(.WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst_n),
        .mem_w_en_in(i2.mw), .mem_r_en_in(i2.mr), .wb_en_in(i2.wb),
        .alu_result_in(i2.alu), .val_rm(i2.val), .pc_in(i2.pc), .dest_in(i2.dest),
        .flush(i2.flush), .freeze(frz2),
        .wb_en(wb2), .mem_r_en(mr2), .alu_result(alu2), .pc(pc2),
        .mem_read_value(rd2), .dest(dst2), .addr_err(ae2)
    );

    mem_stage_ws #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst_n),
        .mem_w_en_in(i0.mw), .mem_r_en_in(i0.mr), .wb_en_in(i0.wb),
        .alu_result_in(i0.alu), .val_rm(i0.val), .pc_in(i0.pc), .dest_in(i0.dest),
        .flush(i0.flush), .freeze(frz0),
        .wb_en(wb0), .mem_r_en(mr0), .alu_result(alu0), .pc(pc0),
        .mem_read_value(rd0), .dest(dst0), .addr_err(ae0)
    );

    assign o2 = {wb2, mr2, ae2, alu2, pc2, rd2, dst2};
    assign o0 = {wb0, mr0, ae0, alu0, pc0, rd0, dst0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, act, exp);
        end
    endtask

    task automatic cmp_out(input string p, input out_t o, input out_t e);
        chk({p, "_pc"},       o.pc,       e.pc);
        chk({p, "_wb_en"},    o.wb_en,    e.wb_en);
        chk({p, "_mem_r_en"}, o.mem_r_en, e.mem_r_en);
        chk({p, "_addr_err"}, o.addr_err, e.addr_err);
        chk({p, "_alu"},      o.alu,      e.alu);
        chk({p, "_rd"},       o.rd,       e.rd);
        chk({p, "_dest"},     o.dest,     e.dest);
    endtask

    // Scoreboard retirement: any nonzero PC on the outputs is a completed instruction.
    always @(negedge clk) begin
        if (rst_n && o2.pc != 32'd0) begin
            if (q2.size() == 0) chk("d2_unexpected_out", o2.pc, 64'd0);
            else cmp_out("d2", o2, q2.pop_front());
        end
        if (rst_n && o0.pc != 32'd0) begin
            if (q0.size() == 0) chk("d0_unexpected_out", o0.pc, 64'd0);
            else cmp_out("d0", o0, q0.pop_front());
        end
        if (frz0) frz0_seen <= 1'b1;
    end

    function automatic logic get_frz(input int d);
        return (d == 0) ? frz0 : frz2;
    endfunction

    task automatic set_in(input int d, input in_t v);
        if (d == 0) i0 = v;
        else        i2 = v;
    endtask

    // Issue one instruction, predict its result, hold it through freeze and
    // return just after its completion edge with the inputs idled.
    task automatic issue(input int d, input logic w, input logic r, input logic wb,
                         input logic [31:0] addr, input logic [31:0] val,
                         input logic [31:0] pcv, input logic [3:0] dst);
        out_t e;
        in_t  v;
        logic vld;
        int   idx;
        int   nfrz;
        int   exp_frz;
        vld = (addr[1:0] == 2'b00) && (addr >= 32'd1024) && (((addr - 32'd1024) >> 2) < 32'd64);
        idx = vld ? int'((addr - 32'd1024) >> 2) : 0;
        e.pc       = pcv;
        e.alu      = addr;
        e.dest     = dst;
        e.addr_err = (w || r) && !vld;
        e.mem_r_en = r && !w && vld;
        e.wb_en    = (e.addr_err && r && !w) ? 1'b0 : wb;
        e.rd       = e.mem_r_en ? ((d == 0) ? mdl0[idx] : mdl2[idx]) : 32'd0;
        if (w && vld) begin
            if (d == 0) mdl0[idx] = val;
            else        mdl2[idx] = val;
        end
        exp_frz = ((w || r) && vld && d != 0) ? 2 : 0;
        if (d == 0) q0.push_back(e);
        else        q2.push_back(e);
        v = '{mw: w, mr: r, wb: wb, alu: addr, val: val, pc: pcv, dest: dst, flush: 1'b0};
        set_in(d, v);
        #1;
        nfrz = 0;
        while (get_frz(d) && nfrz < 20) begin
            nfrz++;
            @(posedge clk); #2;
        end
        chk($sformatf("frz_len_d%0d_pc%0h", d, pcv), 64'(nfrz), 64'(exp_frz));
        @(posedge clk); #1;
        set_in(d, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i2 = '0;
        i0 = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_out2", 64'(o2), 64'd0);
        chk("rst_out0", 64'(o0), 64'd0);
        chk("rst_frz2", frz2, 0);
        chk("rst_frz0", frz0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain ALU op passes straight through.
        issue(2, 0, 0, 1, 32'd7, 32'd0, 32'h10, 4'd3);

        // Store then load, back to back.
        issue(2, 1, 0, 0, 32'd1028, 32'hDEADBEEF, 32'h14, 4'd0);
        issue(2, 0, 1, 1, 32'd1028, 32'd0, 32'h18, 4'd2);

        // Boundaries: first and last words, plus a combined load+store request.
        issue(2, 1, 0, 0, 32'd1024, 32'h01020304, 32'h1C, 4'd0);
        issue(2, 1, 0, 0, 32'd1276, 32'hA0B0C0D0, 32'h20, 4'd0);
        issue(2, 0, 1, 1, 32'd1276, 32'd0, 32'h24, 4'd4);
        issue(2, 1, 1, 1, 32'd1040, 32'h55AA55AA, 32'h28, 4'd6);
        issue(2, 0, 1, 1, 32'd1040, 32'd0, 32'h2C, 4'd7);

        // Squashed accesses: misaligned, one past the end, below base, bad store.
        issue(2, 0, 1, 1, 32'd1026, 32'd0, 32'h30, 4'd1);
        issue(2, 0, 1, 1, 32'd1024 + 32'd256, 32'd0, 32'h34, 4'd1);
        issue(2, 0, 1, 1, 32'd1020, 32'd0, 32'h38, 4'd1);
        issue(2, 1, 0, 1, 32'd1026, 32'hFFFFFFFF, 32'h3C, 4'd9);
        issue(2, 0, 1, 1, 32'd1024, 32'd0, 32'h40, 4'd8);

        // Flush in the final wait cycle: no write, no output.
        issue(2, 1, 0, 0, 32'd1032, 32'hCAFEF00D, 32'h44, 4'd0);
        i2 = '{mw: 1'b1, mr: 1'b0, wb: 1'b0, alu: 32'd1032, val: 32'h22222222,
               pc: 32'h48, dest: 4'd0, flush: 1'b0};
        @(posedge clk); #1;
        @(posedge clk); #1;
        i2.flush = 1'b1;
        #1;
        chk("flush_late_frz", frz2, 0);
        @(posedge clk); #1;
        i2 = '0;
        // Flush in the arrival cycle drops freeze immediately.
        i2 = '{mw: 1'b1, mr: 1'b0, wb: 1'b0, alu: 32'd1032, val: 32'h33333333,
               pc: 32'h4C, dest: 4'd0, flush: 1'b1};
        #1;
        chk("flush_arrival_frz", frz2, 0);
        @(posedge clk); #1;
        i2 = '0;
        #1;
        chk("post_flush_frz", frz2, 0);
        @(posedge clk); #1;
        issue(2, 0, 1, 1, 32'd1032, 32'd0, 32'h50, 4'd5);

        // Asynchronous reset clears a live output.
        issue(2, 1, 0, 0, 32'd1036, 32'h12345678, 32'h54, 4'd0);
        issue(2, 0, 0, 1, 32'h77, 32'd0, 32'h58, 4'd5);
        #6;
        chk("pre_rst_alu", alu2, 32'h77);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", 64'(o2), 64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a store's wait: the store is lost.
        i2 = '{mw: 1'b1, mr: 1'b0, wb: 1'b0, alu: 32'd1036, val: 32'h99999999,
               pc: 32'h5C, dest: 4'd0, flush: 1'b0};
        @(posedge clk); #2;
        rst_n = 1'b0;
        i2 = '0;
        #1;
        chk("midwait_rst_out", 64'(o2), 64'd0);
        chk("midwait_rst_frz", frz2, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2, 0, 1, 1, 32'd1036, 32'd0, 32'h60, 4'd2);

        // Zero-wait instance.
        issue(0, 0, 0, 1, 32'd9, 32'd0, 32'h100, 4'd1);
        issue(0, 1, 0, 0, 32'd1024, 32'hA5A5A5A5, 32'h104, 4'd0);
        issue(0, 0, 1, 1, 32'd1024, 32'd0, 32'h108, 4'd3);
        issue(0, 0, 1, 1, 32'd1025, 32'd0, 32'h10C, 4'd3);

        repeat (3) @(posedge clk);
        #1;
        chk("d0_freeze_seen", frz0_seen, 0);
        chk("d2_sb_left", 64'(q2.size()), 64'd0);
        chk("d0_sb_left", 64'(q0.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
